// File: rtl/mux_2to1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_2to1_pkg
// Description : Shared defaults and helper functions for the mux_2to1 slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_2to1_pkg;

    localparam int unsigned DEF_WIDTH = 1;
    localparam int unsigned DEF_CNT_W = 8;

    // Helper operand widths; WIDTH must not exceed LANE_MAX, CNT_W must not exceed CNT_MAX.
    localparam int unsigned LANE_MAX  = 64;
    localparam int unsigned BUS_MAX   = 2 * LANE_MAX;
    localparam int unsigned CNT_MAX   = 32;

    function automatic logic [LANE_MAX-1:0] lane_sel(
        input logic [BUS_MAX-1:0] bus,
        input int unsigned        width,
        input logic               sel
    );
        logic [BUS_MAX-1:0] shifted;
        shifted = sel ? (bus >> width) : bus;
        return shifted[LANE_MAX-1:0];
    endfunction

    function automatic logic [CNT_MAX-1:0] sat_inc(
        input logic [CNT_MAX-1:0] value,
        input int unsigned        width
    );
        logic [CNT_MAX-1:0] max_v;
        max_v = {CNT_MAX{1'b1}} >> (CNT_MAX - width);
        return (value == max_v) ? value : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_2to1_swcnt.sv
`default_nettype none
// ============================================================================
// Module      : mux_2to1_swcnt
// Description : Saturating counter of select changes between valid cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_2to1_swcnt
    import mux_2to1_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             sel,
    output logic [CNT_W-1:0] sw_cnt
);

    logic               last_sel;
    logic               seen_first;
    logic [CNT_MAX-1:0] cnt_next;
    logic               unused_cnt;

    assign cnt_next   = sat_inc(CNT_MAX'(sw_cnt), CNT_W);
    assign unused_cnt = &{1'b0, cnt_next};

    // The first valid cycle only establishes a reference select value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_cnt     <= '0;
            last_sel   <= 1'b0;
            seen_first <= 1'b0;
        end else if (in_valid) begin
            last_sel   <= sel;
            seen_first <= 1'b1;
            if (seen_first && (sel != last_sel)) begin
                sw_cnt <= cnt_next[CNT_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_2to1.sv
`default_nettype none
// ============================================================================
// Module      : mux_2to1
// Description : Two-lane selector with combinational and registered outputs
//               plus a select-switch counter. MUX_2TO1_PARITY_EN adds y_par.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] d,
    input  logic               sel,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   y,
    output logic [WIDTH-1:0]   y_q,
    output logic               out_valid,
    output logic [CNT_W-1:0]   sw_cnt
`ifdef MUX_2TO1_PARITY_EN
,   output logic               y_par
`endif
);

    logic [LANE_MAX-1:0] lane_full;
    logic                unused_lane;

    assign lane_full   = lane_sel(BUS_MAX'(d), WIDTH, sel);
    assign y           = lane_full[WIDTH-1:0];
    assign unused_lane = &{1'b0, lane_full};

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            y_q       <= y;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_2TO1_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            y_par <= 1'b0;
        end else if (in_valid) begin
            y_par <= ^y;
        end
    end
`endif

    mux_2to1_swcnt #(
        .CNT_W (CNT_W)
    ) u_swcnt (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .sel      (sel),
        .sw_cnt   (sw_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_2to1
// Description : Directed self-checking bench for mux_2to1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_2to1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  d1;
    logic        sel1;
    logic        iv1;
    logic        y1, yq1, ov1;
    logic [7:0]  cnt1;

    logic [15:0] d8;
    logic        sel8;
    logic        iv8;
    logic [7:0]  y8, yq8;
    logic        ov8;
    logic [7:0]  cnt8;

    logic [7:0]  yc2, yqc2;
    logic        ovc2;
    logic [1:0]  cntc2;

`ifdef MUX_2TO1_PARITY_EN
    logic        par1, par8, parc2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_2to1 #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst), .d(d1), .sel(sel1), .in_valid(iv1),
        .y(y1), .y_q(yq1), .out_valid(ov1), .sw_cnt(cnt1)
`ifdef MUX_2TO1_PARITY_EN
        , .y_par(par1)
`endif
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst(rst), .d(d8), .sel(sel8), .in_valid(iv8),
        .y(y8), .y_q(yq8), .out_valid(ov8), .sw_cnt(cnt8)
`ifdef MUX_2TO1_PARITY_EN
        , .y_par(par8)
`endif
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .d(d8), .sel(sel8), .in_valid(iv8),
        .y(yc2), .y_q(yqc2), .out_valid(ovc2), .sw_cnt(cntc2)
`ifdef MUX_2TO1_PARITY_EN
        , .y_par(parc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic valid_sel(input logic s);
        sel8 = s;
        iv8  = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; d1 = 2'b00; sel1 = 1'b0; iv1 = 1'b0;
        d8 = 16'h0000; sel8 = 1'b0; iv8 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_yq",  32'(yq8),  32'h0);
        chk("reset_ov",  32'(ov8),  32'h0);
        chk("reset_cnt", 32'(cnt8), 32'h0);

        // WIDTH=1 combinational truth table
        d1 = 2'b01; sel1 = 1'b0; #1 chk("w1_01_s0", 32'(y1), 32'h1);
        sel1 = 1'b1;             #1 chk("w1_01_s1", 32'(y1), 32'h0);
        d1 = 2'b10; sel1 = 1'b0; #1 chk("w1_10_s0", 32'(y1), 32'h0);
        sel1 = 1'b1;             #1 chk("w1_10_s1", 32'(y1), 32'h1);
        d1 = 2'b00;              #1 chk("w1_00_s1", 32'(y1), 32'h0);
        sel1 = 1'b0;             #1 chk("w1_00_s0", 32'(y1), 32'h0);

        // WIDTH=8 registered path
        d8 = {8'hA5, 8'h3C};
        valid_sel(1'b0);
        chk("w8_yq_cap", 32'(yq8), 32'h3C);
        chk("w8_ov_cap", 32'(ov8), 32'h1);
        chk("w8_cnt_first", 32'(cnt8), 32'h0);
        iv8 = 1'b0; sel8 = 1'b1;
        tick();
        chk("w8_ov_drop", 32'(ov8), 32'h0);
        chk("w8_yq_hold", 32'(yq8), 32'h3C);
        chk("w8_y_s1",    32'(y8),  32'hA5);

        // Switch counter: valid 0,1,1,0,1 after reset
        rst = 1'b1; tick(); rst = 1'b0;
        valid_sel(1'b0); valid_sel(1'b1); valid_sel(1'b1);
        valid_sel(1'b0); valid_sel(1'b1);
        chk("cnt_seq",   32'(cnt8), 32'h3);
        chk("yq_seq",    32'(yq8),  32'hA5);
        iv8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel8 = ~sel8;
            tick();
        end
        chk("cnt_invalid", 32'(cnt8), 32'h3);

        // Saturation: CNT_W=2 saturates while CNT_W=8 keeps counting
        rst = 1'b1; tick(); rst = 1'b0;
        valid_sel(1'b0); valid_sel(1'b1); valid_sel(1'b0);
        chk("c2_cnt_2", 32'(cntc2), 32'h2);
        valid_sel(1'b1); valid_sel(1'b0); valid_sel(1'b1); valid_sel(1'b0);
        chk("c2_cnt_sat", 32'(cntc2), 32'h3);
        chk("w8_cnt_6",   32'(cnt8),  32'h6);

        // Mid-stream reset with in_valid high: reset wins, y stays live
        d8 = {8'h5A, 8'hC3}; sel8 = 1'b1; iv8 = 1'b1; rst = 1'b1;
        #1 chk("rst_y_live", 32'(y8), 32'h5A);
        tick();
        chk("rst_yq",   32'(yq8),  32'h0);
        chk("rst_ov",   32'(ov8),  32'h0);
        chk("rst_cnt",  32'(cnt8), 32'h0);
        chk("rst_cnt2", 32'(cntc2), 32'h0);
        sel8 = 1'b0;
        #1 chk("rst_y_live2", 32'(y8), 32'hC3);
        rst = 1'b0; iv8 = 1'b0;
        tick();
        chk("post_rst_ov", 32'(ov8), 32'h0);
        chk("post_rst_yq", 32'(yq8), 32'h0);

`ifdef MUX_2TO1_PARITY_EN
        chk("par_reset", 32'(par8), 32'h0);
        d8 = {8'h07, 8'h00};
        valid_sel(1'b1);
        chk("par_07", 32'(par8), 32'h1);
        chk("par_yq", 32'(yq8),  32'h07);
        d8 = {8'h03, 8'h00};
        valid_sel(1'b1);
        chk("par_03", 32'(par8), 32'h0);
        iv8 = 1'b0; d8 = {8'h01, 8'h00};
        tick();
        chk("par_hold", 32'(par8), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_2to1.md
Name: mux_2to1

Overview:
Two-input selector with WIDTH-bit lanes packed into one bus `d`.
- Combinational output `y` returns lane `d[sel]` with zero latency.
- A registered copy `y_q`, with a valid flag, gives a timing-clean output for downstream pipelines.
- A saturating counter tracks select switches for debug and observability.
- Used as a generic datapath steering primitive.

Parameters:
- WIDTH, 1, bit width of each data lane and of `y`/`y_q`.
- CNT_W, 8, width of the select-switch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- d  input  2*WIDTH  packed lanes: lane0 = d[WIDTH-1:0], lane1 = d[2*WIDTH-1:WIDTH].
- sel  input  1  0 selects lane0, 1 selects lane1.
- in_valid  input  1  qualifies d/sel for the registered path.
- y  output  WIDTH  combinational selected lane.
- y_q  output  WIDTH  registered selected lane.
- out_valid  output  1  y_q holds a sample captured from a valid input.
- sw_cnt  output  CNT_W  count of sel transitions seen on valid cycles.

Interface decision: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- y = sel ? lane1 : lane0. Purely combinational, independent of clk/rst, no latency.
- If sel is X/Z, y is X in simulation. Synthesis needs no special handling.
- Registered path, on each rising edge of clk:
  - rst=1: y_q<=0, out_valid<=0, sw_cnt<=0, internal last_sel<=0, seen_first<=0.
  - else if in_valid=1: y_q<=y, out_valid<=1.
  - else: y_q holds, out_valid<=0.
- Latency of the registered path: 1 cycle from in_valid to out_valid/y_q.
- Switch counter, only on in_valid cycles:
  - First valid cycle after reset: record last_sel<=sel, set seen_first. No increment.
  - Later valid cycles: if sel != last_sel, sw_cnt increments. last_sel<=sel.
  - sw_cnt saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-stream clears all registered state on that edge. y stays live throughout.
- in_valid=1 together with rst=1: reset wins.
- No back-pressure. Every valid input is captured.

Optional Feature:
- Macro MUX_2TO1_PARITY_EN.
- Defined: adds output `y_par` (1 bit), the registered even parity (XOR reduce) of y, updated exactly when y_q updates. Reset value 0.
- Undefined: port `y_par` and its logic are absent. All other behaviour is identical.

Decomposition:
- Package mux_2to1_pkg holds:
  - default WIDTH/CNT_W localparams;
  - a function for lane extraction from the packed bus;
  - the saturating-increment function.
- One natural sub-module: mux_2to1_swcnt, covering the last_sel tracking and the saturating counter.
- Mux and output register remain in the top.

Test Plan:
- WIDTH=1, no clocking: d=01,sel=0 -> y=1; sel=1 -> y=0; d=10,sel=0 -> y=0; sel=1 -> y=1; d=00 either sel -> y=0.
- WIDTH=8, d={8'hA5,8'h3C}:
  - sel=0,in_valid=1 for one cycle -> next cycle y_q=8'h3C, out_valid=1.
  - Drop in_valid -> out_valid=0, y_q holds 8'h3C.
- Valid sel sequence 0,1,1,0,1 -> sw_cnt=3. Invalid cycles with toggling sel -> sw_cnt unchanged.
- CNT_W=2, 6 valid alternating toggles -> sw_cnt saturates at 3.
- Mid-stream reset:
  - after activity, rst=1 for one cycle -> y_q=0, out_valid=0, sw_cnt=0;
  - y still tracks d/sel during reset;
  - in_valid=1 with rst=1 -> no capture.
- With MUX_2TO1_PARITY_EN, d lane1=8'h07, sel=1 valid -> next cycle y_par=1.
